// File: rtl/dmem_boot_loader.sv
// Boot loader: turns a framed big-endian byte stream (length, data words, XOR checksum)
// into one-cycle writes on the data memory boot port, then flags done or err.
module dmem_boot_loader #(
  parameter logic [31:0] BASE_WADDR = 32'd0,
  parameter int unsigned MAX_WORDS  = 64
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [31:0] boot_daddr,
  output logic [31:0] boot_ddata,
  output logic        boot_dwe,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    ST_LEN  = 3'd0,
    ST_DATA = 3'd1,
    ST_CSUM = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  localparam logic [31:0] MAX_LEN = 32'(MAX_WORDS);

  state_t      state_reg, state_next;
  logic [1:0]  cnt_reg, cnt_next;
  logic [31:0] asm_reg, asm_next;
  logic [31:0] len_reg, len_next;
  logic [31:0] index_reg, index_next;
  logic [31:0] acc_reg, acc_next;
  logic        dwe_reg, dwe_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] data_reg, data_next;

  logic        ready_int;
  logic        accept;
  logic        word_done;
  logic [31:0] word_full;
  logic [31:0] index_inc;

  // Ready is a pure decode of the state register, so it never depends on in_valid.
  assign ready_int = (state_reg == ST_LEN) || (state_reg == ST_DATA) ||
                     (state_reg == ST_CSUM);
  assign accept    = in_valid && ready_int;
  assign word_done = accept && (cnt_reg == 2'd3);
  assign word_full = {asm_reg[23:0], in_data};
  assign index_inc = index_reg + 32'd1;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    asm_next   = asm_reg;
    len_next   = len_reg;
    index_next = index_reg;
    acc_next   = acc_reg;
    dwe_next   = 1'b0;
    addr_next  = addr_reg;
    data_next  = data_reg;

    if (start) begin
      // Restart wins over any byte in the same cycle, including a word-completing one.
      state_next = ST_LEN;
      cnt_next   = 2'd0;
      asm_next   = 32'd0;
      index_next = 32'd0;
      acc_next   = 32'd0;
    end else if (accept) begin
      cnt_next = cnt_reg + 2'd1;
      asm_next = word_full;
      if (word_done) begin
        case (state_reg)
          ST_LEN: begin
            len_next   = word_full;
            index_next = 32'd0;
            acc_next   = 32'd0;
            if (word_full > MAX_LEN) begin
              state_next = ST_ERR;
            end else if (word_full == 32'd0) begin
              state_next = ST_CSUM;
            end else begin
              state_next = ST_DATA;
            end
          end
          ST_DATA: begin
            dwe_next   = 1'b1;
            addr_next  = BASE_WADDR + index_reg;
            data_next  = word_full;
            acc_next   = acc_reg ^ word_full;
            index_next = index_inc;
            if (index_inc == len_reg) begin
              state_next = ST_CSUM;
            end
          end
          ST_CSUM: begin
            state_next = (word_full == acc_reg) ? ST_DONE : ST_ERR;
          end
          default: begin
            state_next = state_reg;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= ST_LEN;
      cnt_reg   <= 2'd0;
      asm_reg   <= 32'd0;
      len_reg   <= 32'd0;
      index_reg <= 32'd0;
      acc_reg   <= 32'd0;
      dwe_reg   <= 1'b0;
      addr_reg  <= 32'd0;
      data_reg  <= 32'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      asm_reg   <= asm_next;
      len_reg   <= len_next;
      index_reg <= index_next;
      acc_reg   <= acc_next;
      dwe_reg   <= dwe_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
    end
  end

  assign in_ready   = ready_int;
  assign boot_dwe   = dwe_reg;
  assign boot_daddr = addr_reg;
  assign boot_ddata = data_reg;
  assign done       = (state_reg == ST_DONE);
  assign err        = (state_reg == ST_ERR);

endmodule

// File: tb/tb_dmem_boot_loader.sv
// Directed bench for dmem_boot_loader: one instance at base 0 and one at base 16 share the stream.
module tb_dmem_boot_loader;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;

  logic        in_ready0, dwe0, done0, err0;
  logic [31:0] addr0, data0;
  logic        in_ready16, dwe16, done16, err16;
  logic [31:0] addr16, data16;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [31:0] wr0_addr [16];
  logic [31:0] wr0_data [16];
  int          wr0_cyc  [16];
  int          wr0_n = 0;
  logic [31:0] wr16_addr [16];
  logic [31:0] wr16_data [16];
  int          wr16_n = 0;

  dmem_boot_loader #(.BASE_WADDR(32'd0), .MAX_WORDS(64)) u_dut (
    .clk(clk), .resetn(resetn), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready0), .boot_daddr(addr0), .boot_ddata(data0), .boot_dwe(dwe0),
    .done(done0), .err(err0)
  );

  dmem_boot_loader #(.BASE_WADDR(32'd16), .MAX_WORDS(64)) u_dut16 (
    .clk(clk), .resetn(resetn), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready16), .boot_daddr(addr16), .boot_ddata(data16), .boot_dwe(dwe16),
    .done(done16), .err(err16)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Write log, sampled mid-cycle so each one-cycle pulse is captured exactly once.
  always @(negedge clk) begin
    if (dwe0 && wr0_n < 16) begin
      wr0_addr[wr0_n] = addr0;
      wr0_data[wr0_n] = data0;
      wr0_cyc[wr0_n]  = cyc;
      $display("write base0  #%0d addr=%0d data=%h cycle=%0d", wr0_n, addr0, data0, cyc);
      wr0_n++;
    end
    if (dwe16 && wr16_n < 16) begin
      wr16_addr[wr16_n] = addr16;
      wr16_data[wr16_n] = data16;
      $display("write base16 #%0d addr=%0d data=%h", wr16_n, addr16, data16);
      wr16_n++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic apply_reset();
    resetn = 1'b0;
    in_valid = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    wr0_n = 0;
    wr16_n = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic send_byte_gapped(input logic [7:0] b);
    int gap;
    gap = 1 + $urandom_range(0, 2);
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    send_byte(b);
  endtask

  task automatic send_word_gapped(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte_gapped(w[i*8 +: 8]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #3;
    checks++; if (in_ready0 !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready0); end
    checks++; if (dwe0 !== 1'b0) begin failures++; $display("FAIL reset_dwe: got %b expected 0", dwe0); end
    checks++; if (addr0 !== 32'd0) begin failures++; $display("FAIL reset_addr: got %h expected 0", addr0); end
    checks++; if (data0 !== 32'd0) begin failures++; $display("FAIL reset_data: got %h expected 0", data0); end
    checks++; if (done0 !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done0); end
    checks++; if (err0 !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", err0); end
    $display("test_reset done");
    apply_reset();
  endtask

  task automatic test_good_frame();
    apply_reset();
    send_word(32'd2);
    send_word(32'h11223344);
    send_word(32'hAABBCCDD);
    send_word(32'hBB99FF99);
    checks++; if (done0 !== 1'b1) begin failures++; $display("FAIL good_done: got %b expected 1", done0); end
    checks++; if (err0 !== 1'b0) begin failures++; $display("FAIL good_err: got %b expected 0", err0); end
    checks++; if (in_ready0 !== 1'b0) begin failures++; $display("FAIL good_in_ready: got %b expected 0", in_ready0); end
    checks++; if (wr0_n !== 2) begin failures++; $display("FAIL good_write_count: got %0d expected 2", wr0_n); end
    checks++; if (wr0_addr[0] !== 32'd0 || wr0_data[0] !== 32'h11223344) begin failures++;
      $display("FAIL good_write0: got addr=%h data=%h expected addr=0 data=11223344", wr0_addr[0], wr0_data[0]); end
    checks++; if (wr0_addr[1] !== 32'd1 || wr0_data[1] !== 32'hAABBCCDD) begin failures++;
      $display("FAIL good_write1: got addr=%h data=%h expected addr=1 data=aabbccdd", wr0_addr[1], wr0_data[1]); end
    checks++; if (wr0_cyc[1] - wr0_cyc[0] !== 4) begin failures++;
      $display("FAIL good_write_spacing: got %0d expected 4", wr0_cyc[1] - wr0_cyc[0]); end
    checks++; if (dwe0 !== 1'b0 || addr0 !== 32'd1 || data0 !== 32'hAABBCCDD) begin failures++;
      $display("FAIL good_port_hold: got dwe=%b addr=%h data=%h expected dwe=0 addr=1 data=aabbccdd", dwe0, addr0, data0); end
    $display("test_good_frame done");
  endtask

  task automatic test_bad_checksum();
    apply_reset();
    send_word(32'd2);
    send_word(32'h11223344);
    send_word(32'hAABBCCDD);
    send_word(32'hBB99FF98);
    checks++; if (err0 !== 1'b1) begin failures++; $display("FAIL badcs_err: got %b expected 1", err0); end
    checks++; if (done0 !== 1'b0) begin failures++; $display("FAIL badcs_done: got %b expected 0", done0); end
    checks++; if (wr0_n !== 2) begin failures++; $display("FAIL badcs_write_count: got %0d expected 2", wr0_n); end
    checks++; if (wr0_data[1] !== 32'hAABBCCDD) begin failures++; $display("FAIL badcs_write1: got %h expected aabbccdd", wr0_data[1]); end
    $display("test_bad_checksum done");
  endtask

  task automatic test_oversize();
    apply_reset();
    send_word(32'd65);
    checks++; if (err0 !== 1'b1) begin failures++; $display("FAIL over_err: got %b expected 1", err0); end
    checks++; if (in_ready0 !== 1'b0) begin failures++; $display("FAIL over_in_ready: got %b expected 0", in_ready0); end
    send_word(32'h12345678);
    send_word(32'h9ABCDEF0);
    checks++; if (wr0_n !== 0) begin failures++; $display("FAIL over_write_count: got %0d expected 0", wr0_n); end
    checks++; if (err0 !== 1'b1 || done0 !== 1'b0) begin failures++; $display("FAIL over_sticky: got err=%b done=%b expected err=1 done=0", err0, done0); end
    pulse_start();
    checks++; if (in_ready0 !== 1'b1 || err0 !== 1'b0) begin failures++;
      $display("FAIL over_restart: got in_ready=%b err=%b expected in_ready=1 err=0", in_ready0, err0); end
    $display("test_oversize done");
  endtask

  task automatic test_empty_base();
    apply_reset();
    send_word(32'd0);
    send_word(32'd0);
    checks++; if (done16 !== 1'b1 || err16 !== 1'b0) begin failures++;
      $display("FAIL empty_done: got done=%b err=%b expected done=1 err=0", done16, err16); end
    checks++; if (wr16_n !== 0) begin failures++; $display("FAIL empty_write_count: got %0d expected 0", wr16_n); end
    apply_reset();
    send_word(32'd1);
    send_word(32'hDEADBEEF);
    send_word(32'hDEADBEEF);
    checks++; if (done16 !== 1'b1) begin failures++; $display("FAIL one_done: got %b expected 1", done16); end
    checks++; if (wr16_n !== 1) begin failures++; $display("FAIL one_write_count: got %0d expected 1", wr16_n); end
    checks++; if (wr16_addr[0] !== 32'd16 || wr16_data[0] !== 32'hDEADBEEF) begin failures++;
      $display("FAIL one_write: got addr=%h data=%h expected addr=10 data=deadbeef", wr16_addr[0], wr16_data[0]); end
    $display("test_empty_base done");
  endtask

  task automatic test_gapped_restart();
    apply_reset();
    send_word_gapped(32'd2);
    send_word_gapped(32'h01020304);
    send_byte_gapped(8'h55);
    send_byte_gapped(8'h66);
    pulse_start();
    checks++; if (in_ready0 !== 1'b1) begin failures++; $display("FAIL gap_restart_ready: got %b expected 1", in_ready0); end
    send_word_gapped(32'd1);
    send_word_gapped(32'hCAFEF00D);
    send_word_gapped(32'hCAFEF00D);
    checks++; if (done0 !== 1'b1 || err0 !== 1'b0) begin failures++;
      $display("FAIL gap_done: got done=%b err=%b expected done=1 err=0", done0, err0); end
    checks++; if (wr0_n !== 2) begin failures++; $display("FAIL gap_write_count: got %0d expected 2", wr0_n); end
    checks++; if (wr0_addr[0] !== 32'd0 || wr0_data[0] !== 32'h01020304) begin failures++;
      $display("FAIL gap_write0: got addr=%h data=%h expected addr=0 data=01020304", wr0_addr[0], wr0_data[0]); end
    checks++; if (wr0_addr[1] !== 32'd0 || wr0_data[1] !== 32'hCAFEF00D) begin failures++;
      $display("FAIL gap_write1: got addr=%h data=%h expected addr=0 data=cafef00d", wr0_addr[1], wr0_data[1]); end
    $display("test_gapped_restart done");
  endtask

  task automatic test_start_collision();
    apply_reset();
    send_word(32'd2);
    send_word(32'h0A0B0C0D);
    send_byte(8'h21);
    send_byte(8'h22);
    send_byte(8'h23);
    start = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h24;
    @(posedge clk);
    #1;
    start = 1'b0;
    in_valid = 1'b0;
    checks++; if (dwe0 !== 1'b0) begin failures++; $display("FAIL collide_no_write: got dwe=%b expected 0", dwe0); end
    checks++; if (in_ready0 !== 1'b1) begin failures++; $display("FAIL collide_ready: got %b expected 1", in_ready0); end
    send_word(32'd0);
    send_word(32'd0);
    checks++; if (done0 !== 1'b1) begin failures++; $display("FAIL collide_done: got %b expected 1", done0); end
    checks++; if (wr0_n !== 1) begin failures++; $display("FAIL collide_write_count: got %0d expected 1", wr0_n); end
    $display("test_start_collision done");
  endtask

  task automatic test_reset_mid();
    apply_reset();
    send_word(32'd3);
    send_word(32'h0BADF00D);
    send_byte(8'h77);
    send_byte(8'h88);
    #3;
    resetn = 1'b0;
    #1;
    checks++; if (in_ready0 !== 1'b1 || dwe0 !== 1'b0 || done0 !== 1'b0 || err0 !== 1'b0) begin failures++;
      $display("FAIL midreset_ctrl: got in_ready=%b dwe=%b done=%b err=%b expected 1 0 0 0", in_ready0, dwe0, done0, err0); end
    checks++; if (addr0 !== 32'd0 || data0 !== 32'd0) begin failures++;
      $display("FAIL midreset_port: got addr=%h data=%h expected 0 0", addr0, data0); end
    @(posedge clk);
    #1;
    resetn = 1'b1;
    wr0_n = 0;
    send_word(32'd2);
    send_word(32'h11223344);
    send_word(32'hAABBCCDD);
    send_word(32'hBB99FF99);
    checks++; if (done0 !== 1'b1 || err0 !== 1'b0) begin failures++;
      $display("FAIL midreset_done: got done=%b err=%b expected done=1 err=0", done0, err0); end
    checks++; if (wr0_n !== 2 || wr0_addr[0] !== 32'd0 || wr0_data[0] !== 32'h11223344) begin failures++;
      $display("FAIL midreset_writes: got n=%0d addr=%h data=%h expected n=2 addr=0 data=11223344", wr0_n, wr0_addr[0], wr0_data[0]); end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_oversize();
    test_empty_base();
    test_gapped_restart();
    test_start_collision();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_boot_loader.md
# dmem_boot_loader

Byte-stream boot loader that fills the data memory through its boot write port (`boot_daddr`, `boot_ddata`, `boot_dwe`) before the processor is released.
- Accepts a framed byte stream and assembles big-endian 32-bit words.
- Writes the words to consecutive word addresses and validates an XOR checksum.
- Reports `done` or `err`; `done` serves as the processor release.

## Interface
- `BASE_WADDR`, default 0: word address of the first data word written.
- `MAX_WORDS`, default 64: largest legal word count; matches the data memory depth.
- `clk`  in  1  single clock for the block.
- `resetn`  in  1  reset, asynchronous and active-low.
- `start`  in  1  one-cycle pulse; re-arms the loader from any state.
- `in_valid`  in  1  `in_data` holds a valid byte.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  the loader can accept a byte this cycle.
- `boot_daddr`  out  32  word address driven to the data memory boot port.
- `boot_ddata`  out  32  write data driven to the boot port.
- `boot_dwe`  out  1  boot port write enable; asserted for exactly one cycle per word.
- `done`  out  1  load completed and checksum matched; sticky.
- `err`  out  1  length or checksum failure; sticky.

## Operation
- **Frame format:** a length word N, then N data words, then one checksum word. The checksum is the XOR of all N data words; the length word is excluded.
- **Byte order:** the first byte of each word goes to [31:24] and the last to [7:0].
- **Handshake:** a byte is accepted when `in_valid & in_ready`. A 2-bit byte counter advances only on accepted bytes, and gaps in `in_valid` are allowed.
- **`in_ready`** is 1 in states LEN, DATA and CSUM, and 0 in DONE and ERR. It is decoded from state only and never depends on `in_valid`.
- **States:**
  - **LEN** (entered at reset). On the 4th accepted byte:
    - N > `MAX_WORDS` -> ERR.
    - N == 0 -> CSUM.
    - Otherwise -> DATA. The word index and checksum accumulator are cleared.
  - **DATA.** On the 4th byte of each word:
    - The next cycle drives `boot_dwe`=1 with `boot_daddr` = `BASE_WADDR` + index and `boot_ddata` = the assembled word.
    - The accumulator is XORed with the word and the index is incremented.
    - After word N-1 -> CSUM.
  - **CSUM.** On the 4th byte: equal to the accumulator -> DONE, otherwise -> ERR.
  - **DONE:** `done`=1, no writes, bytes are ignored.
  - **ERR:** `err`=1, no writes, bytes are ignored.
- **`start`:**
  - Has priority over byte acceptance in the same cycle.
  - Next state is LEN, with the byte counter, index and accumulator cleared and `done`/`err` cleared.
  - Memory already written is not undone.
- **Overwrite:** a write caused by a DATA word is never suppressed, even if the checksum later fails.
- **Address arithmetic:** `boot_daddr` is computed modulo 2^32. The index is 32 bits wide but is bounded by `MAX_WORDS`.
- **Assembly register:** the word assembly register is shared by length, data and checksum words.

## Timing
- **Reset values:**
  - state = LEN, `in_ready`=1.
  - `boot_dwe`=0, `boot_daddr`=0, `boot_ddata`=0.
  - `done`=0, `err`=0.
  - Byte counter, index and accumulator = 0.
- **Reset behaviour:** assertion takes effect immediately, independent of `clk`, and is allowed mid-frame.
- **Register boundary:** all outputs are registered, and no input reaches an output combinationally.
- **Write latency:** the write pulse occurs on the cycle after the 4th byte of a data word is accepted. `boot_daddr` and `boot_ddata` hold their values until the next write; they are not cleared when `boot_dwe` falls.
- **Throughput:** one byte per cycle, so at most one write every 4 cycles. No backpressure is ever needed during LEN, DATA or CSUM.
- **`done`/`err` timing:** each rises on the cycle after the final checksum byte is accepted, or after the length byte for an oversize N. `in_ready` falls in that same cycle.
- **Mutual exclusion:** `done` and `err` are never 1 together.
- **`start` timing:** `start` in cycle t gives `in_ready`=1 in cycle t+1. If `start` coincides with a 4th DATA byte, there is no write.

## Test plan
- **Good frame:** reset, then stream N=2, data 0x11223344 and 0xAABBCCDD, checksum 0xBB99FF99 at one byte per cycle.
  - Exactly two `boot_dwe` pulses: (addr 0, 0x11223344) and (addr 1, 0xAABBCCDD), each 4 cycles apart.
  - `done`=1 one cycle after the last byte, `err`=0, `in_ready`=0.
- **Bad checksum:** same frame with checksum 0xBB99FF98.
  - Both writes still occur.
  - `err`=1, `done`=0.
- **Oversize length:** N=65 with `MAX_WORDS`=64.
  - `err`=1 one cycle after the 4th length byte.
  - No `boot_dwe` pulse, and further bytes are not accepted.
- **Empty frame with base offset:** N=0, checksum 0, `BASE_WADDR`=16.
  - `done`=1 with no writes.
  - Repeat with N=1, data 0xDEADBEEF, checksum 0xDEADBEEF: one write, at addr 16.
- **Gapped input and restart:** `in_valid` toggled every other cycle with random gaps; then `start` after the 2nd byte of data word 1, followed by a fresh frame.
  - Assembly is unaffected by the gaps.
  - After the restart, bytes are reassembled from the first byte, index 0 is rewritten, and `done` follows for the new frame only.
- **Reset mid-operation:** assert `resetn` low between clock edges while in DATA.
  - All outputs go to their reset values immediately.
  - After release, a good frame completes normally.
